// File: rtl/datapath_ctrl_if.sv
// datapath_ctrl_if: instruction handshake (s/instr/w) plus the
// register-file and ALU datapath control bundle driven by datapath_ctrl.
//
// Signals:
//   s, instr            start request and instruction from the source
//   w                   controller idle, ready to accept s
//   readnum, writenum   register file read / write indices
//   write               register file write enable
//   loada/loadb/loadc   A, B and C datapath register loads
//   loads               status register load
//   asel, bsel, vsel    operand and writeback mux selects
//   shift, ALUop        shifter and ALU controls
//   sximm8              sign-extended immediate
//   illegal             one-cycle pulse on an undefined instruction
//
// Modports:
//   master  instruction source / datapath side
//   slave   the controller
interface datapath_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              s;
    logic [15:0]       instr;
    logic              w;
    logic [2:0]        readnum;
    logic [2:0]        writenum;
    logic              write;
    logic              loada;
    logic              loadb;
    logic              loadc;
    logic              loads;
    logic              asel;
    logic              bsel;
    logic [1:0]        vsel;
    logic [1:0]        shift;
    logic [1:0]        ALUop;
    logic [DATA_W-1:0] sximm8;
    logic              illegal;

    modport master (
        output s, instr,
        input  w, readnum, writenum, write,
        input  loada, loadb, loadc, loads,
        input  asel, bsel, vsel, shift, ALUop,
        input  sximm8, illegal
    );

    modport slave (
        input  s, instr,
        output w, readnum, writenum, write,
        output loada, loadb, loadc, loads,
        output asel, bsel, vsel, shift, ALUop,
        output sximm8, illegal
    );
endinterface

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: multi-cycle controller for the 8x16 register file and ALU.
// Ports: clk, reset_n (async, active low), bus (datapath_ctrl_if.slave).
module datapath_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    datapath_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_WB_REG,
        S_WB_IMM
    } state_t;

    typedef enum logic [2:0] {
        K_MOVI,
        K_MOVR,
        K_ADD,
        K_CMP,
        K_AND,
        K_MVN,
        K_ILL
    } kind_t;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic [1:0] shift;
        logic       illegal;
    } ctl_t;

    function automatic kind_t kind_of(input logic [15:0] i);
        kind_t k;
        logic  mov;
        logic  alu;
        mov = (i[15:13] == 3'b110);
        alu = (i[15:13] == 3'b101);
        unique case (1'b1)
            mov && i[12:11] == 2'b10: k = K_MOVI;
            mov && i[12:11] == 2'b00: k = K_MOVR;
            alu && i[12:11] == 2'b00: k = K_ADD;
            alu && i[12:11] == 2'b01: k = K_CMP;
            alu && i[12:11] == 2'b10: k = K_AND;
            alu && i[12:11] == 2'b11: k = K_MVN;
            default:                  k = K_ILL;
        endcase
        return k;
    endfunction

    // Moore decode of a state; evaluated for the next state so the
    // strobes come straight out of flops.
    function automatic ctl_t ctl_of(input state_t st,
                                    input logic [15:0] i);
        ctl_t  c;
        kind_t k;
        c = '0;
        k = kind_of(i);
        unique case (st)
            S_WAIT:   c.w = 1'b1;
            S_DECODE: c.illegal = (k == K_ILL);
            S_LOAD_A: begin
                c.readnum = i[10:8];
                c.loada   = 1'b1;
            end
            S_LOAD_B: begin
                c.readnum = i[2:0];
                c.loadb   = 1'b1;
            end
            S_EXEC: begin
                // MOV reg and MVN ignore A: force it to zero
                c.asel  = (k == K_MOVR) || (k == K_MVN);
                c.shift = i[4:3];
                c.loads = (k == K_CMP);
                c.loadc = (k != K_CMP);
            end
            S_WB_REG: begin
                c.writenum = i[7:5];
                c.write    = 1'b1;
            end
            S_WB_IMM: begin
                c.writenum = i[10:8];
                c.vsel     = 2'b10;
                c.write    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t      state;
    state_t      state_nxt;
    logic [15:0] ir;
    logic [15:0] ir_nxt;
    ctl_t        ctl;
    kind_t       kind;

    assign kind = kind_of(ir);

    always_comb begin
        state_nxt = state;
        ir_nxt    = ir;
        unique case (state)
            S_WAIT: begin
                if (bus.s) begin
                    state_nxt = S_DECODE;
                    ir_nxt    = bus.instr;
                end
            end
            S_DECODE: begin
                unique case (kind)
                    K_MOVI:              state_nxt = S_WB_IMM;
                    K_MOVR, K_MVN:       state_nxt = S_LOAD_B;
                    K_ADD, K_CMP, K_AND: state_nxt = S_LOAD_A;
                    default:             state_nxt = S_WAIT;
                endcase
            end
            S_LOAD_A: state_nxt = S_LOAD_B;
            S_LOAD_B: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = (kind == K_CMP) ? S_WAIT : S_WB_REG;
            S_WB_REG: state_nxt = S_WAIT;
            S_WB_IMM: state_nxt = S_WAIT;
            default:  state_nxt = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_WAIT;
            ir    <= '0;
            ctl   <= '{w: 1'b1, default: '0};
        end else begin
            state <= state_nxt;
            ir    <= ir_nxt;
            ctl   <= ctl_of(state_nxt, ir_nxt);
        end
    end

    assign bus.w        = ctl.w;
    assign bus.readnum  = ctl.readnum;
    assign bus.writenum = ctl.writenum;
    assign bus.write    = ctl.write;
    assign bus.loada    = ctl.loada;
    assign bus.loadb    = ctl.loadb;
    assign bus.loadc    = ctl.loadc;
    assign bus.loads    = ctl.loads;
    assign bus.asel     = ctl.asel;
    assign bus.bsel     = ctl.bsel;
    assign bus.vsel     = ctl.vsel;
    assign bus.shift    = ctl.shift;
    assign bus.illegal  = ctl.illegal;

    // MOV reg runs as ADD with A forced to zero
    assign bus.ALUop  = (kind == K_MOVR) ? 2'b00 : ir[12:11];
    assign bus.sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: random and directed instructions; a strobe-driven
// datapath model is compared against an instruction-level reference.
module tb_datapath_ctrl;

    localparam int DATA_W = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    datapath_ctrl_if #(.DATA_W(DATA_W)) bus ();

    datapath_ctrl #(.DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] shf(input logic [15:0] v,
                                        input logic [1:0] sh);
        case (sh)
            2'b00:   return v;
            2'b01:   return v << 1;
            2'b10:   return v >> 1;
            default: return {v[15], v[15:1]};
        endcase
    endfunction

    function automatic logic [15:0] alu(input logic [1:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return ~b;
        endcase
    endfunction

    // Datapath driven purely by the controller's strobes.
    logic [15:0] rf [8] = '{default: 16'h0};
    logic [15:0] ra = 16'h0;
    logic [15:0] rb = 16'h0;
    logic [15:0] rc = 16'h0;
    logic        zf = 1'b0;
    logic [15:0] ain;
    logic [15:0] bin;
    logic [15:0] res;

    always @(negedge clk) begin
        ain = bus.asel ? 16'h0 : ra;
        bin = bus.bsel ? bus.sximm8 : shf(rb, bus.shift);
        res = alu(bus.ALUop, ain, bin);
        if (bus.loada) ra <= rf[bus.readnum];
        if (bus.loadb) rb <= rf[bus.readnum];
        if (bus.loadc) rc <= res;
        if (bus.loads) zf <= (res == 16'h0);
        if (bus.write)
            rf[bus.writenum] <= (bus.vsel == 2'b10) ? bus.sximm8 : rc;
    end

    // Instruction-level reference
    logic [15:0] rref [8] = '{default: 16'h0};
    logic        zref = 1'b0;

    function automatic bit is_legal(input logic [15:0] i);
        return (i[15:13] == 3'b101) ||
               (i[15:13] == 3'b110 && i[11] == 1'b0);
    endfunction

    function automatic bit is_cmp(input logic [15:0] i);
        return i[15:11] == 5'b10101;
    endfunction

    function automatic int exp_lat(input logic [15:0] i);
        if (!is_legal(i))              return 1;
        if (i[15:11] == 5'b11010)      return 2;
        if (i[15:11] == 5'b11000)      return 4;
        if (i[12:11] inside {2'b00, 2'b10}) return 5;
        return 4;
    endfunction

    task automatic apply_ref(input logic [15:0] i);
        logic [15:0] bv;
        bv = shf(rref[i[2:0]], i[4:3]);
        if (i[15:11] == 5'b11010)
            rref[i[10:8]] = {{8{i[7]}}, i[7:0]};
        else if (i[15:11] == 5'b11000)
            rref[i[7:5]] = bv;
        else if (i[15:13] == 3'b101) begin
            case (i[12:11])
                2'b00: rref[i[7:5]] = rref[i[10:8]] + bv;
                2'b01: zref = ((rref[i[10:8]] - bv) == 16'h0);
                2'b10: rref[i[7:5]] = rref[i[10:8]] & bv;
                default: rref[i[7:5]] = ~bv;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_r%0d", tag, i), rf[i], rref[i]);
    endtask

    task automatic run(input logic [15:0] ins, input bit keep_s);
        int busy;
        int nwr;
        int nld;
        int nill;
        int nviol;
        busy  = 0;
        nwr   = 0;
        nld   = 0;
        nill  = 0;
        nviol = 0;
        bus.s     = 1'b1;
        bus.instr = ins;
        apply_ref(ins);
        step();
        chk("accept", bus.w, 1'b0);
        bus.s     = keep_s;
        bus.instr = 16'($urandom);
        while (bus.w === 1'b0 && busy < 16) begin
            busy++;
            nwr  += int'(bus.write);
            nld  += int'(bus.loads);
            nill += int'(bus.illegal);
            if (!bus.loada && !bus.loadb && bus.readnum != 3'd0) nviol++;
            if (!bus.write && bus.writenum != 3'd0) nviol++;
            if (!bus.loadc && !bus.loads && bus.shift != 2'b00) nviol++;
            if (bus.bsel) nviol++;
            step();
        end
        chk($sformatf("lat_%h", ins), busy, exp_lat(ins));
        chk($sformatf("nwr_%h", ins), nwr,
            (is_legal(ins) && !is_cmp(ins)) ? 1 : 0);
        chk($sformatf("nlds_%h", ins), nld, is_cmp(ins) ? 1 : 0);
        chk($sformatf("nill_%h", ins), nill, is_legal(ins) ? 0 : 1);
        chk($sformatf("unused_%h", ins), nviol, 0);
        chk("idle_strobes",
            {bus.write, bus.loada, bus.loadb, bus.loadc,
             bus.loads, bus.illegal}, 6'b0);
        check_rf("rf");
        if (is_cmp(ins)) chk("zflag", zf, zref);
    endtask

    initial begin
        logic [15:0] ins;
        logic [10:0] fld;
        int          k;

        bus.s     = 1'b0;
        bus.instr = 16'h0;

        // power-on reset
        #2 reset_n = 1'b0;
        #1;
        chk("rst_w", bus.w, 1'b1);
        chk("rst_strobes",
            {bus.write, bus.loada, bus.loadb, bus.loadc,
             bus.loads, bus.illegal}, 6'b0);
        chk("rst_sximm8", bus.sximm8, 16'h0);
        chk("rst_shift_aluop", {bus.shift, bus.ALUop}, 4'b0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        step();
        chk("rst_idle", bus.w, 1'b1);

        // seed registers with immediates
        for (int i = 0; i < 8; i++)
            run({5'b11010, 3'(i), 8'($urandom)}, 1'b0);

        // MOV R3,#-5 cycle by cycle
        bus.s     = 1'b1;
        bus.instr = 16'hD3FB;
        apply_ref(16'hD3FB);
        step();
        chk("movi_dec_w", bus.w, 1'b0);
        bus.s = 1'b0;
        step();
        chk("movi_wn", bus.writenum, 3'd3);
        chk("movi_vsel", bus.vsel, 2'b10);
        chk("movi_write", bus.write, 1'b1);
        chk("movi_imm", bus.sximm8, 16'hFFFB);
        step();
        chk("movi_done", bus.w, 1'b1);
        check_rf("movi");

        // ADD R2,R1,R0,LSL#1 cycle by cycle
        bus.s     = 1'b1;
        bus.instr = 16'hA148;
        apply_ref(16'hA148);
        step();
        bus.s     = 1'b0;
        bus.instr = 16'hFFFF;
        step();
        chk("add_la", {bus.loada, bus.readnum}, {1'b1, 3'd1});
        step();
        chk("add_lb", {bus.loadb, bus.readnum}, {1'b1, 3'd0});
        step();
        chk("add_lc", {bus.loadc, bus.shift, bus.ALUop},
            {1'b1, 2'b01, 2'b00});
        step();
        chk("add_wb", {bus.write, bus.writenum}, {1'b1, 3'd2});
        step();
        chk("add_done", bus.w, 1'b1);
        check_rf("add");

        run(16'hAD06, 1'b0);
        run(16'h0000, 1'b0);

        // back to back with s held high
        run(16'hC0E1, 1'b1);
        run(16'hB8AA, 1'b0);

        for (int n = 0; n < 200; n++) begin
            k   = $urandom_range(0, 7);
            fld = 11'($urandom);
            case (k)
                0:       ins = {5'b11010, fld};
                1:       ins = {5'b11000, fld};
                2, 3, 4, 5: ins = {3'b101, 2'(k - 2), fld};
                default: ins = 16'($urandom);
            endcase
            run(ins, (n == 199) ? 1'b0 : 1'($urandom_range(0, 1)));
        end

        // reset during LOAD_B of an ADD
        bus.s     = 1'b1;
        bus.instr = 16'hA3A4;
        step();
        bus.s = 1'b0;
        step();
        step();
        chk("mid_loadb", bus.loadb, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_w", bus.w, 1'b1);
        chk("mid_rst_strobes",
            {bus.write, bus.loada, bus.loadb, bus.loadc,
             bus.loads, bus.illegal}, 6'b0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        step();
        step();
        chk("mid_after_w", bus.w, 1'b1);
        check_rf("mid");
        run(16'hA148, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
Multi-cycle FSM that sequences the 8x16 register file and its ALU datapath. It latches one 16-bit instruction per start request, then drives the read/write ports and the datapath load and select strobes cycle by cycle until the result is written back. It sits between the instruction source (testbench or fetch unit) and the datapath; `w` tells the source when a new instruction can be accepted.

Parameters:
DATA_W, 16, datapath width; width of `sximm8`.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- s  input  1  start request; sampled only in WAIT
- instr  input  16  instruction; captured on the start edge
- w  output  1  1 = idle, ready to accept `s`
- readnum  output  3  register file read index
- writenum  output  3  register file write index
- write  output  1  register file write enable
- loada  output  1  A operand register load
- loadb  output  1  B operand register load
- loadc  output  1  C result register load
- loads  output  1  status register load
- asel  output  1  1 = A input forced to 0
- bsel  output  1  1 = B input is `sximm8`
- vsel  output  2  writeback mux: 00 = C, 10 = sximm8
- shift  output  2  shifter control (latched `instr[4:3]`)
- ALUop  output  2  ALU operation (latched `instr[12:11]`)
- sximm8  output  DATA_W  sign-extended latched `instr[7:0]`
- illegal  output  1  one-cycle pulse on an undefined instruction

Behaviour:
- Instruction fields (from the latched copy): opcode [15:13], op [12:11], Rn [10:8], Rd [7:5], sh [4:3], Rm [2:0].
- Supported instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD Rd,Rn,Rm
  - 101/01 CMP Rn,Rm
  - 101/10 AND Rd,Rn,Rm
  - 101/11 MVN Rd,Rm
  - All other encodings are illegal.
- States: WAIT, DECODE, LOAD_A, LOAD_B, EXEC, WB_REG, WB_IMM.
- Outputs are Moore, decoded from state plus the latched instruction.
- All strobes (`write`, `loada`, `loadb`, `loadc`, `loads`, `illegal`) are 0 in every state unless listed below.
- WAIT:
  - `w`=1.
  - On `s`=1 at a clock edge: latch `instr` and go to DECODE.
  - Otherwise stay in WAIT.
- DECODE (`w`=0):
  - MOV imm → WB_IMM.
  - MOV reg or MVN → LOAD_B.
  - ADD, CMP or AND → LOAD_A.
  - Illegal → WAIT, with `illegal`=1 during the DECODE cycle.
- LOAD_A: `readnum`=Rn, `loada`=1 → LOAD_B.
- LOAD_B: `readnum`=Rm, `loadb`=1 → EXEC.
- EXEC: `bsel`=0.
  - `asel`=1 for MOV reg and MVN; `asel`=0 otherwise.
  - CMP: `loads`=1 → WAIT.
  - All others: `loadc`=1 → WB_REG.
- WB_REG: `writenum`=Rd, `vsel`=00, `write`=1 → WAIT.
- WB_IMM: `writenum`=Rn, `vsel`=10, `write`=1 → WAIT.
- `ALUop` for MOV reg is forced to 00 (ADD with A=0).
- `shift` is forced to 00 in every state except EXEC.
- Latency (cycles from the accepting edge back to `w`=1):
  - MOV imm: 2
  - MOV reg / MVN: 4
  - ADD / AND: 5
  - CMP: 4
  - Illegal: 1
- `s` held high continuously: a new instruction is accepted on the first edge in WAIT. `instr` changes while busy are ignored.
- `readnum` and `writenum` output 000 when not in use; `write`=0 guarantees no write occurs.
- Reset (`reset_n`=0, asynchronous):
  - State → WAIT, `w`=1, all strobes 0 immediately.
  - Latched instruction → 0, so `sximm8`=0, `shift`=00, `ALUop`=00.
- Reset asserted mid-instruction aborts it; a pending write never occurs.
- Release of reset is synchronous to the next clk edge.
- `sximm8` is imm8 sign-extended to DATA_W: bit 7 is replicated into the upper bits.

Test Plan:
- Reset mid-flight: assert `reset_n`=0 during LOAD_B of an ADD → `w`=1 and `write`=0 within the same cycle. After release, the state is WAIT and no register changes.
- MOV R3,#-5: `instr`=16'hD3FB, `s`=1 →
  - edge+1: DECODE, `w`=0.
  - edge+2: WB_IMM, `writenum`=3, `vsel`=10, `write`=1, `sximm8`=16'hFFFB.
  - edge+3: `w`=1.
- ADD R2,R1,R0,LSL#1: `instr`=16'hA148 → strobes in order:
  1. `loada` with `readnum`=1
  2. `loadb` with `readnum`=0
  3. `loadc` with `shift`=01, `ALUop`=00
  4. `write` with `writenum`=2
  
  `w` returns to 1 five cycles after the start edge.
- CMP R5,R6: `instr`=16'hAD06 → `loads`=1 in EXEC, `write` never asserted, back to WAIT after 4 cycles.
- Illegal `instr`=16'h0000 → `illegal`=1 for exactly 1 cycle, no strobes, `w`=1 after 1 cycle.
- Back-to-back: `s` held high across MOV reg then MVN → second instruction accepted on the first edge `w`=1 is seen. `instr` changes during the first instruction have no effect on its fields.
